benes_cfg_loader: RTL and testbench

Upstream configuration stage for the 8x8 Benes network. It accepts per-stage switch-setting words over a valid/ready handshake into a shadow register. On a frame-sync pulse it commits the full configuration atomically to the `switch_set` inputs of every `switch_module` instance. The datapath therefore never sees a partially loaded permutation.

---
 rtl/benes_cfg_loader.sv | 87 ++++++++
 tb/tb_benes_cfg_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/benes_cfg_loader.sv
// Configuration loader for the 8x8 Benes network: collects per-stage switch words into a shadow
// register and commits the whole permutation atomically on a frame sync.
module benes_cfg_loader #(
    parameter int unsigned N_STAGES = 5,
    parameter int unsigned N_SW     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SW-1:0]            i_cfg_data,
    input  logic                       i_cfg_valid,
    output logic                       o_cfg_ready,
    input  logic                       i_cfg_abort,
    input  logic                       i_frame_sync,
    output logic [N_STAGES*N_SW-1:0]   o_switch_set,
    output logic                       o_commit,
    output logic                       o_cfg_busy,
    output logic [2:0]                 o_stage_cnt
);

    localparam int unsigned CfgW = N_STAGES * N_SW;
    localparam logic [2:0]  LastStage = 3'(N_STAGES - 1);

    typedef enum logic [0:0] {
        StLoad,
        StWaitSync
    } state_e;

    state_e            state_q;
    logic [2:0]        stage_cnt_q;
    logic [CfgW-1:0]   shadow_q;
    logic [CfgW-1:0]   switch_set_q;
    logic              commit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StLoad;
            stage_cnt_q  <= 3'd0;
            shadow_q     <= '0;
            switch_set_q <= '0;
            commit_q     <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            // Abort beats both a pending transfer and a coincident sync.
            if (i_cfg_abort) begin
                state_q     <= StLoad;
                stage_cnt_q <= 3'd0;
            end else begin
                unique case (state_q)
                    StLoad: begin
                        if (i_cfg_valid) begin
                            for (int unsigned s = 0; s < N_STAGES; s++) begin
                                if (stage_cnt_q == 3'(s)) begin
                                    shadow_q[s*N_SW +: N_SW] <= i_cfg_data;
                                end
                            end
                            stage_cnt_q <= stage_cnt_q + 3'd1;
                            if (stage_cnt_q == LastStage) begin
                                state_q <= StWaitSync;
                            end
                        end
                    end
                    StWaitSync: begin
                        if (i_frame_sync) begin
                            switch_set_q <= shadow_q;
                            stage_cnt_q  <= 3'd0;
                            commit_q     <= 1'b1;
                            state_q      <= StLoad;
                        end
                    end
                    default: begin
                        state_q     <= StLoad;
                        stage_cnt_q <= 3'd0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        o_cfg_ready  = (state_q == StLoad) && !rst;
        o_cfg_busy   = (stage_cnt_q != 3'd0) || (state_q == StWaitSync);
        o_switch_set = switch_set_q;
        o_commit     = commit_q;
        o_stage_cnt  = stage_cnt_q;
    end

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Directed bench for benes_cfg_loader: load, commit, abort, back-pressure and reset sequences.
module tb_benes_cfg_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i_cfg_data;
    logic        i_cfg_valid;
    logic        o_cfg_ready;
    logic        i_cfg_abort;
    logic        i_frame_sync;
    logic [19:0] o_switch_set;
    logic        o_commit;
    logic        o_cfg_busy;
    logic [2:0]  o_stage_cnt;

    int n_vec = 0;
    int n_err = 0;

    benes_cfg_loader #(
        .N_STAGES(5),
        .N_SW    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cfg_data  (i_cfg_data),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_cfg_abort (i_cfg_abort),
        .i_frame_sync(i_frame_sync),
        .o_switch_set(o_switch_set),
        .o_commit    (o_commit),
        .o_cfg_busy  (o_cfg_busy),
        .o_stage_cnt (o_stage_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] w);
        i_cfg_valid = 1'b1;
        i_cfg_data  = w;
        tick();
        i_cfg_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        i_cfg_valid  = 1'b1;
        i_cfg_data   = 4'h3;
        i_cfg_abort  = 1'b0;
        i_frame_sync = 1'b0;

        // Reset held two cycles with valid high
        tick();
        tick();
        chk("rst_switch_set", 32'(o_switch_set), 32'h00000);
        chk("rst_ready", 32'(o_cfg_ready), 32'd0);
        chk("rst_commit", 32'(o_commit), 32'd0);
        chk("rst_busy", 32'(o_cfg_busy), 32'd0);
        rst         = 1'b0;
        i_cfg_valid = 1'b0;
        #1;
        chk("rel_ready", 32'(o_cfg_ready), 32'd1);
        chk("rel_cnt", 32'(o_stage_cnt), 32'd0);

        // Full load, sync three cycles later
        send(4'h1);
        chk("load_cnt1", 32'(o_stage_cnt), 32'd1);
        chk("load_busy1", 32'(o_cfg_busy), 32'd1);
        send(4'h2);
        send(4'h4);
        send(4'h8);
        send(4'hF);
        chk("full_ready", 32'(o_cfg_ready), 32'd0);
        chk("full_cnt", 32'(o_stage_cnt), 32'd5);
        tick();
        tick();
        chk("pre_sync_set", 32'(o_switch_set), 32'h00000);
        chk("pre_sync_commit", 32'(o_commit), 32'd0);
        i_frame_sync = 1'b1;
        tick();
        i_frame_sync = 1'b0;
        chk("sync_set", 32'(o_switch_set), 32'hF8421);
        chk("sync_commit", 32'(o_commit), 32'd1);
        chk("sync_ready", 32'(o_cfg_ready), 32'd1);
        chk("sync_cnt", 32'(o_stage_cnt), 32'd0);
        tick();
        chk("post_commit", 32'(o_commit), 32'd0);
        chk("post_set", 32'(o_switch_set), 32'hF8421);

        // Sync coincident with last word, then back-pressure
        send(4'h1);
        send(4'h2);
        send(4'h3);
        send(4'h4);
        i_frame_sync = 1'b1;
        send(4'h5);
        chk("coin_commit", 32'(o_commit), 32'd0);
        chk("coin_ready", 32'(o_cfg_ready), 32'd0);
        chk("coin_busy", 32'(o_cfg_busy), 32'd1);
        chk("coin_set", 32'(o_switch_set), 32'hF8421);
        i_frame_sync = 1'b0;
        i_cfg_valid  = 1'b1;
        i_cfg_data   = 4'h3;
        tick();
        tick();
        chk("bp_ready", 32'(o_cfg_ready), 32'd0);
        chk("bp_cnt", 32'(o_stage_cnt), 32'd5);
        chk("bp_commit", 32'(o_commit), 32'd0);
        i_frame_sync = 1'b1;
        tick();
        i_frame_sync = 1'b0;
        i_cfg_valid  = 1'b0;
        chk("bp_sync_set", 32'(o_switch_set), 32'h54321);
        chk("bp_sync_commit", 32'(o_commit), 32'd1);
        tick();
        chk("bp_idle_cnt", 32'(o_stage_cnt), 32'd0);

        // Abort mid-load with a coincident valid word
        send(4'h5);
        send(4'h5);
        chk("ab_cnt2", 32'(o_stage_cnt), 32'd2);
        i_cfg_abort = 1'b1;
        send(4'h7);
        i_cfg_abort = 1'b0;
        chk("ab_cnt", 32'(o_stage_cnt), 32'd0);
        chk("ab_busy", 32'(o_cfg_busy), 32'd0);
        chk("ab_ready", 32'(o_cfg_ready), 32'd1);
        for (int i = 0; i < 5; i++) send(4'hA);
        i_frame_sync = 1'b1;
        tick();
        i_frame_sync = 1'b0;
        chk("ab_reload_set", 32'(o_switch_set), 32'hAAAAA);
        chk("ab_reload_commit", 32'(o_commit), 32'd1);

        // Abort in WAIT_SYNC with coincident sync
        send(4'h1);
        send(4'h2);
        send(4'h4);
        send(4'h8);
        send(4'hF);
        i_cfg_abort  = 1'b1;
        i_frame_sync = 1'b1;
        tick();
        i_cfg_abort = 1'b0;
        chk("aw_commit", 32'(o_commit), 32'd0);
        chk("aw_set", 32'(o_switch_set), 32'hAAAAA);
        chk("aw_ready", 32'(o_cfg_ready), 32'd1);
        chk("aw_cnt", 32'(o_stage_cnt), 32'd0);
        tick();
        i_frame_sync = 1'b0;
        chk("aw_load_sync", 32'(o_commit), 32'd0);
        chk("aw_load_set", 32'(o_switch_set), 32'hAAAAA);

        // Back-to-back with sync held high: commit on the sixth edge
        i_frame_sync = 1'b1;
        for (int i = 0; i < 5; i++) send(4'h9);
        chk("b2b_nocommit", 32'(o_commit), 32'd0);
        tick();
        i_frame_sync = 1'b0;
        chk("b2b_set", 32'(o_switch_set), 32'h99999);
        chk("b2b_commit", 32'(o_commit), 32'd1);

        // Reset mid-operation
        send(4'h1);
        send(4'h2);
        send(4'h4);
        send(4'h8);
        send(4'hF);
        i_frame_sync = 1'b1;
        tick();
        i_frame_sync = 1'b0;
        chk("rm_set", 32'(o_switch_set), 32'hF8421);
        send(4'h6);
        send(4'h6);
        send(4'h6);
        chk("rm_cnt3", 32'(o_stage_cnt), 32'd3);
        rst = 1'b1;
        tick();
        chk("rm_rst_set", 32'(o_switch_set), 32'h00000);
        chk("rm_rst_cnt", 32'(o_stage_cnt), 32'd0);
        chk("rm_rst_busy", 32'(o_cfg_busy), 32'd0);
        chk("rm_rst_ready", 32'(o_cfg_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rm_rel_ready", 32'(o_cfg_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
